// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates an instruction-fetch port and a data-memory port
// onto one shared memory. Round-robin on ties, one access at a time, with a
// wait-counter timeout and a sticky error flag.
module mem_arb_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        if_stall,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    output logic        dm_stall,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    // Last counter value before the timeout fires; an ACC cycle without
    // mem_done at this value would make the counter reach MAX_WAIT.
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;
    typedef enum logic {GNT_IF, GNT_DM} grant_t;

    state_t        state, state_n;
    grant_t        last_grant;
    logic [CW-1:0] wait_cnt;

    logic dm_req, dm_bad, dm_ok;
    logic grant_dm, grant_if;
    logic timeout, finish;

    // Request decode and round-robin pick; a simultaneous rd+wr is illegal
    // and never reaches the memory.
    always_comb begin
        dm_req   = dm_rd | dm_wr;
        dm_bad   = dm_rd & dm_wr;
        dm_ok    = dm_req & ~dm_bad;
        grant_dm = dm_ok & (~if_req | (last_grant == GNT_IF));
        grant_if = if_req & ~grant_dm;
        timeout  = ~mem_done & (wait_cnt == WAIT_LAST);
        finish   = mem_done | timeout;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_dm)      state_n = DM_ACC;
                else if (grant_if) state_n = IF_ACC;
            end
            IF_ACC, DM_ACC: begin
                if (finish) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command capture at grant, completion/timeout handling, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_IF;
            wait_cnt   <= '0;
            mem_wr     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= 16'h0000;
            dm_rdata   <= 16'h0000;
            err        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_dm) begin
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        mem_wr     <= dm_wr;
                        last_grant <= GNT_DM;
                    end else if (grant_if) begin
                        mem_addr   <= if_addr;
                        mem_wdata  <= 16'h0000;
                        mem_wr     <= 1'b0;
                        last_grant <= GNT_IF;
                    end
                    // Illegal data request: flag it and release the requester.
                    if (dm_bad) begin
                        err      <= 1'b1;
                        dm_valid <= 1'b1;
                    end
                end
                IF_ACC: begin
                    if (mem_done) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else if (timeout) begin
                        if_valid <= 1'b1;
                        if_rdata <= 16'h0000;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DM_ACC: begin
                    if (mem_done) begin
                        dm_valid <= 1'b1;
                        // Writes leave the last read data in place.
                        if (!mem_wr) dm_rdata <= mem_rdata;
                    end else if (timeout) begin
                        dm_valid <= 1'b1;
                        dm_rdata <= 16'h0000;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en   = (state != IDLE);
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

endmodule
